// File: rtl/full_adder_pkg.sv
// Shared constants and the single-bit full-adder primitive for the full_adder slice.
// The optional signed-overflow flag is enabled by defining FA_OVERFLOW_EN.
package full_adder_pkg;

    localparam int FA_MIN_WIDTH = 1;
    localparam int FA_MAX_WIDTH = 64;

    // Returns {carry_out, sum} for one bit position.
    function automatic logic [1:0] fa_bit(input logic a, input logic b, input logic c);
        logic w_s;
        logic w_cy;
        w_s  = a ^ b ^ c;
        w_cy = (a & b) | (a & c) | (b & c);
        return {w_cy, w_s};
    endfunction

endpackage

// File: rtl/full_adder_fa_cell.sv
// Combinational 1-bit full adder; one link of the ripple chain in full_adder.
module fa_cell
    import full_adder_pkg::*;
(
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_cy
);

    logic [1:0] w_res;

    assign w_res = fa_bit(i_a, i_b, i_c);
    assign o_s   = w_res[0];
    assign o_cy  = w_res[1];

endmodule

// File: rtl/full_adder.sv
// Registered WIDTH-bit ripple adder with carry-in: {cy, s} = a + b + c, one-cycle latency.
// Define FA_OVERFLOW_EN to add the registered signed-overflow output ovf.
module full_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    output logic [WIDTH-1:0] s,
    output logic             cy,
    output logic             out_valid
`ifdef FA_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    generate
        if (WIDTH < FA_MIN_WIDTH || WIDTH > FA_MAX_WIDTH) begin : g_width_check
            $error("full_adder: WIDTH=%0d outside legal range 1..64", WIDTH);
        end
    endgenerate

    // Valid-only protocol: an operation is accepted on every edge where in_valid=1 and
    // rst=0; out_valid is high for exactly the cycle after acceptance. There is no ready.
    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;

    assign w_carry[0] = c;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chain
            fa_cell u_cell (
                .i_a  (a[gi]),
                .i_b  (b[gi]),
                .i_c  (w_carry[gi]),
                .o_s  (w_sum[gi]),
                .o_cy (w_carry[gi+1])
            );
        end
    endgenerate

    logic [WIDTH-1:0] r_s;
    logic             r_cy;
    logic             r_valid;

    // s/cy keep the last accepted result while idle; only out_valid drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s     <= '0;
            r_cy    <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_s  <= w_sum;
                r_cy <= w_carry[WIDTH];
            end
        end
    end

    assign s         = r_s;
    assign cy        = r_cy;
    assign out_valid = r_valid;

`ifdef FA_OVERFLOW_EN
    logic w_ovf;
    logic r_ovf;

    // Two's-complement overflow: like-signed operands produced a sum of the other sign.
    assign w_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (in_valid) begin
            r_ovf <= w_ovf;
        end
    end

    assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_full_adder.sv
// Scoreboard bench for full_adder at WIDTH 1, 4 and 16 driven from one shared stimulus stream.
// Checks ovf as well when FA_OVERFLOW_EN is defined.
module tb_full_adder;

  localparam int NI = 3;
  localparam int W1 = 1;
  localparam int W4 = 4;
  localparam int W16 = 16;

  logic clk;
  logic rst;
  logic in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic c;

  logic [W1-1:0] s1;
  logic [W4-1:0] s4;
  logic [W16-1:0] s16;
  logic cy1, cy4, cy16;
  logic ov1, ov4, ov16;
  logic ovf1, ovf4, ovf16;

  int n_total;
  int n_pass;

  // Each entry: {ovf, full (WIDTH+1)-bit sum zero-extended to 17 bits}
  logic [17:0] exp_q[NI][$];
  logic [17:0] last_v[NI];
  logic [17:0] got[NI];
  logic ovalid[NI];
  int widths[NI];

  logic rst_at_edge;
  logic mon_en;

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  full_adder #(.WIDTH(W1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a[W1-1:0]), .b(b[W1-1:0]), .c(c),
    .s(s1), .cy(cy1), .out_valid(ov1)
`ifdef FA_OVERFLOW_EN
    , .ovf(ovf1)
`endif
  );

  full_adder #(.WIDTH(W4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a[W4-1:0]), .b(b[W4-1:0]), .c(c),
    .s(s4), .cy(cy4), .out_valid(ov4)
`ifdef FA_OVERFLOW_EN
    , .ovf(ovf4)
`endif
  );

  full_adder #(.WIDTH(W16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .c(c),
    .s(s16), .cy(cy16), .out_valid(ov16)
`ifdef FA_OVERFLOW_EN
    , .ovf(ovf16)
`endif
  );

`ifndef FA_OVERFLOW_EN
  assign ovf1 = 1'b0;
  assign ovf4 = 1'b0;
  assign ovf16 = 1'b0;
`endif

  assign got[0] = {ovf1, 15'd0, cy1, s1};
  assign got[1] = {ovf4, 12'd0, cy4, s4};
  assign got[2] = {ovf16, cy16, s16};
  assign ovalid[0] = ov1;
  assign ovalid[1] = ov4;
  assign ovalid[2] = ov16;

  // Reference model: plain integer arithmetic on the operands masked to the width.
  function automatic logic [17:0] model(input int w, input logic [15:0] aa,
                                        input logic [15:0] bb, input logic cc);
    longint m, am, bm, sum, sa, sb, ssum, hi, lo;
    logic ov;
    logic [17:0] r;
    m = (longint'(1) << w) - 1;
    am = longint'(aa) & m;
    bm = longint'(bb) & m;
    sum = am + bm + longint'(cc);
    sa = (am >= (longint'(1) << (w - 1))) ? am - (longint'(1) << w) : am;
    sb = (bm >= (longint'(1) << (w - 1))) ? bm - (longint'(1) << w) : bm;
    ssum = sa + sb + longint'(cc);
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -(longint'(1) << (w - 1));
`ifdef FA_OVERFLOW_EN
    ov = (ssum > hi) || (ssum < lo);
`else
    ov = 1'b0;
`endif
    r = {ov, sum[16:0]};
    return r;
  endfunction

  task automatic check(input string name, input int idx, input logic [17:0] act,
                       input logic [17:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s width=%0d got=%h expected=%h at %0t", name, widths[idx], act, expv, $time);
  endtask

  // driver task: one cycle of stimulus, expected result queued when the op is accepted
  task automatic drive(input logic v, input logic r, input logic [15:0] aa,
                       input logic [15:0] bb, input logic cc);
    @(posedge clk);
    #1;
    in_valid = v;
    rst = r;
    a = aa;
    b = bb;
    c = cc;
    if (v && !r)
      for (int i = 0; i < NI; i++) exp_q[i].push_back(model(widths[i], aa, bb, cc));
  endtask

  always @(posedge clk) rst_at_edge = rst;

  // monitor / scoreboard
  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < NI; i++) begin
        if (rst_at_edge) begin
          check("reset_state", i, {got[i][17:1], got[i][0] | ovalid[i]}, 18'd0);
          last_v[i] = 18'd0;
        end else if (ovalid[i]) begin
          if (exp_q[i].size() == 0) begin
            check("unexpected_out_valid", i, 18'd1, 18'd0);
          end else begin
            logic [17:0] e;
            e = exp_q[i].pop_front();
            check("result", i, got[i], e);
            last_v[i] = e;
          end
        end else begin
          check("idle_hold", i, got[i], last_v[i]);
        end
      end
    end
  end

  initial begin
    logic [15:0] ra, rb;
    widths[0] = W1;
    widths[1] = W4;
    widths[2] = W16;
    n_total = 0;
    n_pass = 0;
    mon_en = 1'b0;
    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    c = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    drive(1'b0, 1'b1, 16'h0, 16'h0, 1'b0);
    // single op, then the three-op back-to-back sequence
    drive(1'b1, 1'b0, 16'h1, 16'h0, 1'b1);
    drive(1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    drive(1'b1, 1'b0, 16'h1, 16'h1, 1'b1);
    drive(1'b1, 1'b0, 16'h1, 16'h0, 1'b0);
    // exhaustive single-bit combos
    for (int k = 0; k < 8; k++) drive(1'b1, 1'b0, 16'(k & 1), 16'((k >> 1) & 1), k[2]);
    // wrap-around, overflow boundary, then idle hold
    drive(1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b1);
    drive(1'b1, 1'b0, 16'h0007, 16'h0001, 1'b0);
    drive(1'b1, 1'b0, 16'h7FFF, 16'h0001, 1'b0);
    drive(1'b1, 1'b0, 16'h8000, 16'h8000, 1'b0);
    drive(1'b0, 1'b0, 16'h1234, 16'h4321, 1'b1);
    drive(1'b0, 1'b0, 16'hAAAA, 16'h5555, 1'b0);
    // reset overrides a simultaneous valid op
    drive(1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1);
    drive(1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    // randomized ops with toggling valid and rare resets
    for (int n = 0; n < 1000; n++) begin
      ra = 16'($urandom_range(0, 65535));
      rb = 16'($urandom_range(0, 65535));
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0, ra, rb,
            1'($urandom_range(0, 1)));
    end
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    @(negedge clk);
    #1;
    for (int i = 0; i < NI; i++) check("queue_drained", i, 18'(exp_q[i].size()), 18'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
